// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and decoded position/status outputs of the VGA timing decoder
interface vga_sync_decoder_if #(
  parameter int CW = 10
);
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active;
  logic          locked;
  logic          frame_start;
  logic          line_err;

  modport master (
    output hsync, vsync,
    input  x, y, active, locked, frame_start, line_err
  );

  modport slave (
    input  hsync, vsync,
    output x, y, active, locked, frame_start, line_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive timing recovery: position rebuild, line/frame checks, lock tracking
module vga_sync_decoder #(
  parameter int CW         = 10,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_LINES = 4
) (
  input logic              clk,
  input logic              rst_n,
  vga_sync_decoder_if.slave bus
);
  localparam int EW       = CW + 1;
  localparam int LOSS_LIM = 2 * H_TOTAL;
  localparam int LW       = $clog2(LOSS_LIM + 1);
  localparam int GW       = $clog2(LOCK_LINES + 1);
  localparam int H_START  = H_SYNC + H_BP;
  localparam int V_START  = V_SYNC + V_BP;

  localparam logic [CW-1:0] POS_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  logic          hsync_q, vsync_q;
  logic [CW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic [LW-1:0] loss_q, loss_d;
  logic [GW-1:0] good_q, good_d;
  logic          vlock_q, vlock_d;
  state_t        state_q, state_d;

  logic          hs_rise, hs_fall, vs_rise;
  logic [EW-1:0] hpos_e, vpos_e;
  logic          line_bad, width_bad, sig_loss;
  logic          line_err_c;
  logic          locked_c;
  logic          h_in, v_in, active_c;

  assign hs_rise = bus.hsync & ~hsync_q;
  assign hs_fall = ~bus.hsync & hsync_q;
  assign vs_rise = bus.vsync & ~vsync_q;

  // Extended by one bit so a saturated counter never aliases onto a legal length.
  assign hpos_e    = {1'b0, hpos_q};
  assign vpos_e    = {1'b0, vpos_q};
  assign line_bad  = hs_rise & ((hpos_e + EW'(1)) != EW'(H_TOTAL));
  assign width_bad = hs_fall & ((hpos_e + EW'(1)) != EW'(H_SYNC));

  // hpos saturates well below 2*H_TOTAL for small CW, so loss is timed separately.
  assign sig_loss = ~hs_rise & (loss_q >= LW'(LOSS_LIM - 1));

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    loss_d = loss_q;

    if (hs_rise) begin
      hpos_d = '0;
      loss_d = '0;
    end else begin
      if (hpos_q != POS_MAX) hpos_d = hpos_q + CW'(1);
      if (loss_q != LW'(LOSS_LIM)) loss_d = loss_q + LW'(1);
    end

    if (vs_rise) begin
      vpos_d = '0;
    end else if (hs_rise && (vpos_q != POS_MAX)) begin
      vpos_d = vpos_q + CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    line_err_c = 1'b0;

    case (state_q)
      SEARCH: begin
        if (hs_rise) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (line_bad || width_bad) begin
          state_d = SEARCH;
        end else if (hs_rise) begin
          good_d = good_q + GW'(1);
          if (good_q == GW'(LOCK_LINES - 1)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || width_bad) begin
          line_err_c = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (line_bad || width_bad) begin
          line_err_c = 1'b1;
          state_d    = SEARCH;
        end else if (hs_rise) begin
          state_d = LOCKED;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (sig_loss) state_d = SEARCH;
  end

  // Frame length is only trusted once the horizontal timing is already locked.
  always_comb begin
    vlock_d = vlock_q;
    if (vs_rise && (state_q == LOCKED || state_q == HOLD)) begin
      vlock_d = ((vpos_e + EW'(1)) == EW'(V_TOTAL));
    end
    if (state_d == SEARCH) vlock_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      loss_q  <= '0;
      good_q  <= '0;
      vlock_q <= 1'b0;
      state_q <= SEARCH;
    end else begin
      hsync_q <= bus.hsync;
      vsync_q <= bus.vsync;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      loss_q  <= loss_d;
      good_q  <= good_d;
      vlock_q <= vlock_d;
      state_q <= state_d;
    end
  end

  assign locked_c = vlock_q & ((state_q == LOCKED) | (state_q == HOLD));
  assign h_in     = (hpos_e >= EW'(H_START)) & (hpos_e < EW'(H_START + H_ACTIVE));
  assign v_in     = (vpos_e >= EW'(V_START)) & (vpos_e < EW'(V_START + V_ACTIVE));
  assign active_c = locked_c & h_in & v_in;

  assign bus.locked      = locked_c;
  assign bus.active      = active_c;
  assign bus.x           = active_c ? (hpos_q - CW'(H_START)) : '0;
  assign bus.y           = active_c ? (vpos_q - CW'(V_START)) : '0;
  assign bus.frame_start = vs_rise & locked_c;
  assign bus.line_err    = line_err_c;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized self-checking bench for vga_sync_decoder against a timestamp model
module tb_vga_sync_decoder;
  localparam int CW = 6, H_SYNC = 8, H_BP = 4, H_ACTIVE = 16, H_TOTAL = 32;
  localparam int V_SYNC = 2, V_BP = 3, V_ACTIVE = 10, V_TOTAL = 20, LOCK_LINES = 4;
  localparam int PMAX = (1 << CW) - 1;
  localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vga_sync_decoder_if #(.CW(CW)) bus();

  vga_sync_decoder #(
    .CW(CW), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .LOCK_LINES(LOCK_LINES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: positions are elapsed cycles since the last hsync/vsync rise.
  int n, n_hzero, lines, mode, good;
  bit vlock, prev_hs, prev_vs;
  int le_cnt, fs_cnt, pin_a, pin_b, pin_c;
  int len_tab[80];
  int wid_tab[80];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, n);
    end
  endtask

  task automatic step(input bit hs, input bit vs, input bit rst);
    int hp_raw, hp, vp, xe, ye, old;
    bit lk, act, hr, hf, vr, lb, wb;
    @(negedge clk);
    bus.hsync = hs;
    bus.vsync = vs;
    rst_n     = rst;
    #1;
    if (!rst) begin
      chk("reset_x", bus.x, 0);
      chk("reset_y", bus.y, 0);
      chk("reset_active", bus.active, 0);
      chk("reset_locked", bus.locked, 0);
      chk("reset_frame_start", bus.frame_start, 0);
      chk("reset_line_err", bus.line_err, 0);
      n_hzero = n + 1; lines = 0; mode = M_SEARCH; good = 0;
      vlock = 0; prev_hs = 0; prev_vs = 0;
    end else begin
      hp_raw = n - n_hzero;
      hp  = (hp_raw > PMAX) ? PMAX : hp_raw;
      vp  = (lines > PMAX) ? PMAX : lines;
      hr  = hs && !prev_hs;
      hf  = !hs && prev_hs;
      vr  = vs && !prev_vs;
      lb  = hr && (hp_raw + 1 != H_TOTAL);
      wb  = hf && (hp_raw + 1 != H_SYNC);
      lk  = vlock && (mode == M_LOCKED || mode == M_HOLD);
      act = lk && hp >= H_SYNC + H_BP && hp < H_SYNC + H_BP + H_ACTIVE
               && vp >= V_SYNC + V_BP && vp < V_SYNC + V_BP + V_ACTIVE;
      xe  = act ? hp - (H_SYNC + H_BP) : 0;
      ye  = act ? vp - (V_SYNC + V_BP) : 0;

      chk("x", bus.x, xe);
      chk("y", bus.y, ye);
      chk("active", bus.active, act);
      chk("locked", bus.locked, lk);
      chk("frame_start", bus.frame_start, vr && lk);
      chk("line_err", bus.line_err, lk || mode == M_LOCKED || mode == M_HOLD ? (lb || wb) && (mode >= M_LOCKED) : 0);

      if (lk && hp == 12 && vp == 5) begin
        pin_a++;
        chk("pin_first_px_active", bus.active, 1);
        chk("pin_first_px_x", bus.x, 0);
        chk("pin_first_px_y", bus.y, 0);
      end
      if (lk && hp == 27 && vp == 14) begin
        pin_b++;
        chk("pin_last_px_x", bus.x, 15);
        chk("pin_last_px_y", bus.y, 9);
      end
      if (lk && hp == 28 && vp == 14) begin
        pin_c++;
        chk("pin_past_last_px", bus.active, 0);
      end

      old = mode;
      if (!hr && hp_raw + 1 >= 2 * H_TOTAL) begin
        mode = M_SEARCH;
      end else begin
        case (mode)
          M_SEARCH:  if (hr) begin mode = M_MEASURE; good = 0; end
          M_MEASURE: if (lb || wb) mode = M_SEARCH;
                     else if (hr) begin good++; if (good == LOCK_LINES) mode = M_LOCKED; end
          M_LOCKED:  if (lb || wb) mode = M_HOLD;
          default:   if (lb || wb) mode = M_SEARCH; else if (hr) mode = M_LOCKED;
        endcase
      end
      if (vr && (old == M_LOCKED || old == M_HOLD)) vlock = (lines + 1 == V_TOTAL);
      if (mode == M_SEARCH) vlock = 0;
      if (hr) n_hzero = n + 1;
      if (vr) lines = 0; else if (hr) lines++;
      prev_hs = hs;
      prev_vs = vs;
    end
    if (bus.line_err === 1'b1) le_cnt++;
    if (bus.frame_start === 1'b1) fs_cnt++;
    n++;
  endtask

  task automatic ideal_tab();
    for (int i = 0; i < 80; i++) begin
      len_tab[i] = H_TOTAL;
      wid_tab[i] = H_SYNC;
    end
  endtask

  task automatic send_line(input int len, input int wid, input bit vs);
    for (int i = 0; i < len; i++) step(i < wid, vs, 1'b1);
  endtask

  task automatic send_frame(input int nl, input bit vs_en);
    for (int l = 0; l < nl; l++) send_line(len_tab[l], wid_tab[l], vs_en && (l < V_SYNC));
  endtask

  initial begin
    int r, nl;
    bit vs_en;
    rst_n = 1'b0;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    n = 0; n_hzero = 0; lines = 0; mode = M_SEARCH; good = 0;
    vlock = 0; prev_hs = 0; prev_vs = 0;
    le_cnt = 0; fs_cnt = 0; pin_a = 0; pin_b = 0; pin_c = 0;

    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Ideal stream from reset: lock lands on the second frame's vsync rise.
    ideal_tab();
    repeat (3) send_frame(V_TOTAL, 1'b1);
    chk("ideal_locked", bus.locked, 1);
    chk("ideal_frame_starts", fs_cnt, 1);
    chk("ideal_no_line_err", le_cnt, 0);

    ideal_tab();
    len_tab[7] = H_TOTAL - 1;
    le_cnt = 0;
    send_frame(V_TOTAL, 1'b1);
    chk("short_line_err_count", le_cnt, 1);
    chk("short_line_still_locked", bus.locked, 1);

    ideal_tab();
    len_tab[7] = H_TOTAL + 1;
    len_tab[8] = H_TOTAL + 1;
    le_cnt = 0;
    send_frame(V_TOTAL, 1'b1);
    chk("two_long_err_count", le_cnt, 2);
    chk("two_long_unlocked", bus.locked, 0);
    ideal_tab();
    send_frame(V_TOTAL, 1'b1);
    chk("two_long_relocked", bus.locked, 1);

    ideal_tab();
    wid_tab[6] = H_SYNC - 1;
    le_cnt = 0;
    send_frame(V_TOTAL, 1'b1);
    chk("narrow_pulse_err_count", le_cnt, 1);
    chk("narrow_pulse_still_locked", bus.locked, 1);

    repeat (2 * H_TOTAL + 6) step(1'b0, 1'b0, 1'b1);
    chk("loss_unlocked", bus.locked, 0);
    ideal_tab();
    repeat (2) send_frame(V_TOTAL, 1'b1);
    chk("loss_relocked", bus.locked, 1);

    // Reset asserted mid-frame while an active pixel is being decoded.
    ideal_tab();
    for (int l = 0; l < 10; l++) send_line(H_TOTAL, H_SYNC, l < V_SYNC);
    for (int i = 0; i < 20; i++) step(i < H_SYNC, 1'b0, 1'b1);
    chk("midframe_locked_before_reset", bus.locked, 1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (3) send_frame(V_TOTAL, 1'b1);
    chk("reset_relocked", bus.locked, 1);

    for (int f = 0; f < 25; f++) begin
      ideal_tab();
      nl = V_TOTAL;
      vs_en = 1'b1;
      r = int'($urandom_range(0, 9));
      if (r == 0) nl = V_TOTAL - 1;
      else if (r == 1) nl = V_TOTAL + 1;
      else if (r == 2) begin nl = 3 * V_TOTAL + 10; vs_en = 1'b0; end
      for (int l = 0; l < nl; l++) begin
        r = int'($urandom_range(0, 99));
        if (r < 6) len_tab[l] = H_TOTAL + int'($urandom_range(0, 4)) - 2;
        else if (r < 10) wid_tab[l] = H_SYNC + int'($urandom_range(0, 2)) - 1;
        else if (r < 12) len_tab[l] = int'($urandom_range(H_TOTAL + 2, 3 * H_TOTAL));
      end
      send_frame(nl, vs_en);
    end
    ideal_tab();
    repeat (3) send_frame(V_TOTAL, 1'b1);
    chk("random_then_ideal_locked", bus.locked, 1);
    chk("pins_reached", (pin_a > 0) && (pin_b > 0) && (pin_c > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
